// File: rtl/mandel_pkg.sv
// Shared constants, state encoding and colour table for the Mandelbrot pixel path.
package mandel_pkg;

    localparam int FX_W    = 27;
    localparam int FX_FRAC = 23;
    localparam int ITER_W  = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ISSUE,
        ST_WAIT,
        ST_WRITE,
        ST_ADVANCE,
        ST_DONE
    } seq_state_e;

    // RGB332 palette indexed by the MSB position of the escape count
    localparam logic [7:0] COLOR_LUT [0:7] = '{
        8'h03, 8'h07, 8'h1F, 8'h3C, 8'h7C, 8'hF8, 8'hE0, 8'hFF
    };

endpackage

// File: rtl/mandel_pixel_sequencer_if.sv
// Iterator handshake and pixel-memory write port between the sequencer and its peers.
interface mandel_pixel_sequencer_if
    import mandel_pkg::*;
#(
    parameter int ADDR_W = 19
) ();

    logic              iter_init;
    logic [FX_W-1:0]   iter_c_r;
    logic [FX_W-1:0]   iter_c_i;
    logic [ITER_W-1:0] iter_max;
    logic              iter_done;
    logic [ITER_W-1:0] iter_count;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data;

    modport master (
        output iter_init, iter_c_r, iter_c_i, iter_max, mem_we, mem_addr, mem_data,
        input  iter_done, iter_count
    );

    modport slave (
        input  iter_init, iter_c_r, iter_c_i, iter_max, mem_we, mem_addr, mem_data,
        output iter_done, iter_count
    );

endinterface

// File: rtl/mandel_color_map.sv
// Escape count to RGB332 colour: black inside the set, else palette by count magnitude.
module mandel_color_map
    import mandel_pkg::*;
(
    input  logic [ITER_W-1:0] count,
    input  logic [ITER_W-1:0] max_iter,
    output logic [7:0]        color
);

    logic [2:0] idx;

    always_comb begin
        idx = 3'd0;
        for (int i = 0; i < ITER_W; i++) begin
            if (count[i]) idx = (i > 7) ? 3'd7 : 3'(i);
        end
        color = (count >= max_iter) ? 8'h00 : COLOR_LUT[idx];
    end

endmodule

// File: rtl/mandel_pixel_sequencer.sv
// Raster-order frame walker: issues one iterator run per pixel and writes its colour.
//
// state      | meaning
// IDLE       | waiting for go
// LOAD       | latch view, reset x/y/address/coordinates
// ISSUE      | one-cycle iterator restart pulse
// WAIT       | waiting for iterator done
// WRITE      | pixel write strobe
// ADVANCE    | step to next pixel or finish
// DONE       | frame_done pulse
module mandel_pixel_sequencer
    import mandel_pkg::*;
#(
    parameter int H_PIXELS = 640,
    parameter int V_PIXELS = 480,
    parameter int ADDR_W   = 19
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     go,
    input  logic [FX_W-1:0]          x_start,
    input  logic [FX_W-1:0]          y_start,
    input  logic [FX_W-1:0]          dx,
    input  logic [FX_W-1:0]          dy,
    input  logic [ITER_W-1:0]        max_iter,
    mandel_pixel_sequencer_if.master bus,
    output logic                     busy,
    output logic                     frame_done,
    output logic [31:0]              frame_cycles
);

    localparam int XW = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
    localparam int YW = (V_PIXELS > 1) ? $clog2(V_PIXELS) : 1;

    seq_state_e        state_q, state_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [FX_W-1:0]   x_start_q, x_start_d;
    logic [FX_W-1:0]   dx_q, dx_d;
    logic [FX_W-1:0]   dy_q, dy_d;
    logic [FX_W-1:0]   c_r_q, c_r_d;
    logic [FX_W-1:0]   c_i_q, c_i_d;
    logic [ITER_W-1:0] max_q, max_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic              init_q, init_d;
    logic              we_q, we_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [31:0]       fc_q, fc_d;
    logic [7:0]        color_w;

    mandel_color_map u_color_map (
        .count    (bus.iter_count),
        .max_iter (max_q),
        .color    (color_w)
    );

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        x_start_d = x_start_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        c_r_d     = c_r_q;
        c_i_d     = c_i_q;
        max_d     = max_q;
        addr_d    = addr_q;
        data_d    = data_q;
        fc_d      = fc_q;

        if (state_q != ST_IDLE) fc_d = fc_q + 32'd1;

        unique case (state_q)
            ST_IDLE: begin
                if (go) begin
                    state_d = ST_LOAD;
                    fc_d    = 32'd0;
                end
            end
            ST_LOAD: begin
                x_start_d = x_start;
                dx_d      = dx;
                dy_d      = dy;
                max_d     = max_iter;
                x_d       = '0;
                y_d       = '0;
                addr_d    = '0;
                c_r_d     = x_start;
                c_i_d     = y_start;
                state_d   = ST_ISSUE;
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (bus.iter_done) begin
                    data_d  = color_w;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: state_d = ST_ADVANCE;
            ST_ADVANCE: begin
                if (x_q < XW'(H_PIXELS - 1)) begin
                    x_d     = x_q + 1'b1;
                    c_r_d   = c_r_q + dx_q;
                    addr_d  = addr_q + 1'b1;
                    state_d = ST_ISSUE;
                end else if (y_q < YW'(V_PIXELS - 1)) begin
                    x_d     = '0;
                    y_d     = y_q + 1'b1;
                    c_r_d   = x_start_q;
                    c_i_d   = c_i_q - dy_q;
                    addr_d  = addr_q + 1'b1;
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Strobes are registered so they line up exactly with the state they belong to
        init_d = (state_d == ST_ISSUE);
        we_d   = (state_d == ST_WRITE);
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            x_q       <= '0;
            y_q       <= '0;
            x_start_q <= '0;
            dx_q      <= '0;
            dy_q      <= '0;
            c_r_q     <= '0;
            c_i_q     <= '0;
            max_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            init_q    <= 1'b0;
            we_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            fc_q      <= '0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            x_start_q <= x_start_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            c_r_q     <= c_r_d;
            c_i_q     <= c_i_d;
            max_q     <= max_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            init_q    <= init_d;
            we_q      <= we_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            fc_q      <= fc_d;
        end
    end

    assign bus.iter_init = init_q;
    assign bus.iter_c_r  = c_r_q;
    assign bus.iter_c_i  = c_i_q;
    assign bus.iter_max  = max_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_data  = data_q;
    assign busy          = busy_q;
    assign frame_done    = done_q;
    assign frame_cycles  = fc_q;

endmodule

// File: tb/tb_mandel_pixel_sequencer.sv
// Randomized bench for mandel_pixel_sequencer on a 4x3 frame with a behavioural iterator and pixel model.
module tb_mandel_pixel_sequencer;

    localparam int H    = 4;
    localparam int V    = 3;
    localparam int AW   = 4;
    localparam int NPIX = H * V;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        go = 1'b0;
    logic [26:0] x_start = '0, y_start = '0, dx = '0, dy = '0;
    logic [11:0] max_iter = '0;
    logic        busy, frame_done;
    logic [31:0] frame_cycles;

    mandel_pixel_sequencer_if #(.ADDR_W(AW)) bus ();

    mandel_pixel_sequencer #(.H_PIXELS(H), .V_PIXELS(V), .ADDR_W(AW)) dut (
        .clock        (clock),
        .reset        (reset),
        .go           (go),
        .x_start      (x_start),
        .y_start      (y_start),
        .dx           (dx),
        .dy           (dy),
        .max_iter     (max_iter),
        .bus          (bus),
        .busy         (busy),
        .frame_done   (frame_done),
        .frame_cycles (frame_cycles)
    );

    always #10 clock = ~clock;

    int n_chk = 0;
    int n_fail = 0;

    // model state
    logic [26:0] m_xs, m_ys, m_dx, m_dy;
    logic [11:0] m_max;
    int          m_pix, m_wr, nfd, fixed_lat;
    int          sum_cyc;
    bit          frame_act = 1'b0;
    bit          use_tbl = 1'b0;
    bit          pending = 1'b0;
    int          rem;
    logic [11:0] cur_count;
    logic [7:0]  exp_color [NPIX];
    logic [26:0] rec_cr [NPIX];
    logic [26:0] rec_ci [NPIX];
    logic [7:0]  rec_data [NPIX];
    logic [11:0] tbl [4] = '{12'd1000, 12'd0, 12'd5, 12'd600};

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] model_color(input int count, input int mx);
        logic [7:0] lut [8] = '{8'h03, 8'h07, 8'h1F, 8'h3C, 8'h7C, 8'hF8, 8'hE0, 8'hFF};
        int idx;
        int v;
        if (count >= mx) return 8'h00;
        idx = 0;
        v = count;
        while (v > 1) begin
            v = v / 2;
            idx++;
        end
        if (idx > 7) idx = 7;
        return lut[idx];
    endfunction

    // Iterator stand-in plus per-cycle comparison against the pixel model
    always @(negedge clock) begin
        if (!reset) begin
            pending = 1'b0;
        end else begin
            if (bus.iter_init) begin
                check("init_in_frame", {63'd0, frame_act && (m_pix < NPIX)}, 64'd1);
                if (m_pix < NPIX) begin
                    logic [26:0] e_cr, e_ci;
                    int lat;
                    e_cr = m_xs + 27'(m_pix % H) * m_dx;
                    e_ci = m_ys - 27'(m_pix / H) * m_dy;
                    check("iter_c_r", bus.iter_c_r, e_cr);
                    check("iter_c_i", bus.iter_c_i, e_ci);
                    check("iter_max", bus.iter_max, m_max);
                    rec_cr[m_pix] = bus.iter_c_r;
                    rec_ci[m_pix] = bus.iter_c_i;
                    lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
                    if (use_tbl && m_pix < 4) cur_count = tbl[m_pix];
                    else cur_count = 12'($urandom_range(0, int'(m_max)));
                    exp_color[m_pix] = model_color(int'(cur_count), int'(m_max));
                    sum_cyc += 4 + lat;
                    pending = 1'b1;
                    rem = lat;
                    bus.iter_done = 1'b0;
                    m_pix++;
                end
            end else if (pending) begin
                if (rem == 0) begin
                    bus.iter_done = 1'b1;
                    bus.iter_count = cur_count;
                    pending = 1'b0;
                end else begin
                    rem--;
                end
            end
            if (bus.mem_we) begin
                check("we_after_init", {63'd0, frame_act && (m_wr < m_pix)}, 64'd1);
                if (m_wr < m_pix) begin
                    check("mem_addr", bus.mem_addr, m_wr);
                    check("mem_data", bus.mem_data, exp_color[m_wr]);
                    rec_data[m_wr] = bus.mem_data;
                    m_wr++;
                end
            end
            if (frame_done) nfd++;
            if (!frame_act) begin
                check("idle_init", bus.iter_init, 0);
                check("idle_we", bus.mem_we, 0);
                check("idle_busy", busy, 0);
            end
        end
    end

    task automatic start_frame(input logic [26:0] xs, ys, ddx, ddy, input logic [11:0] mx,
                               input int lat, input bit tb_en);
        @(negedge clock);
        x_start = xs; y_start = ys; dx = ddx; dy = ddy; max_iter = mx;
        m_xs = xs; m_ys = ys; m_dx = ddx; m_dy = ddy; m_max = mx;
        m_pix = 0; m_wr = 0; nfd = 0; sum_cyc = 0;
        fixed_lat = lat; use_tbl = tb_en;
        frame_act = 1'b1;
        go = 1'b1;
        @(negedge clock);
        go = 1'b0;
    endtask

    task automatic finish_frame();
        bit got = 1'b0;
        for (int i = 0; i < 5000 && !got; i++) begin
            @(negedge clock);
            if (frame_done) got = 1'b1;
        end
        check("frame_done_seen", {63'd0, got}, 64'd1);
        @(negedge clock);
        check("frame_cycles", frame_cycles, 2 + sum_cyc);
        check("pixels_written", m_wr, NPIX);
        check("frame_done_pulses", nfd, 1);
        check("busy_after", busy, 0);
        frame_act = 1'b0;
    endtask

    task automatic wait_pix(input int n);
        bit ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clock);
            if (m_pix >= n) ok = 1'b1;
        end
        check("reached_pixel", {63'd0, ok}, 64'd1);
    endtask

    initial begin
        bus.iter_done  = 1'b0;
        bus.iter_count = '0;
        fixed_lat = 0;

        // reset and idle
        repeat (3) @(negedge clock);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_frame_cycles", frame_cycles, 0);
        check("rst_init", bus.iter_init, 0);
        check("rst_we", bus.mem_we, 0);
        check("rst_addr", bus.mem_addr, 0);
        check("rst_c_r", bus.iter_c_r, 0);
        check("rst_data", bus.mem_data, 0);
        reset = 1'b1;
        repeat (20) @(negedge clock);

        // model pins for the colour map
        check("model_in_set", model_color(1000, 1000), 8'h00);
        check("model_zero", model_color(0, 1000), 8'h03);
        check("model_five", model_color(5, 1000), 8'h1F);
        check("model_clamp", model_color(600, 1000), 8'hFF);

        // small literal frame, latency 2
        start_frame(27'h7000000, 27'h0800000, 27'h0400000, 27'h0400000, 12'd20, 2, 1'b0);
        finish_frame();
        check("lit_cr0", rec_cr[0], 27'h7000000);
        check("lit_cr1", rec_cr[1], 27'h7400000);
        check("lit_cr2", rec_cr[2], 27'h7800000);
        check("lit_cr3", rec_cr[3], 27'h7C00000);
        check("lit_cr4", rec_cr[4], 27'h7000000);
        check("lit_ci0", rec_ci[0], 27'h0800000);
        check("lit_ci4", rec_ci[4], 27'h0400000);
        check("lit_ci8", rec_ci[8], 27'h0000000);
        check("lit_frame_cycles", frame_cycles, 74);

        // colour map through the DUT
        start_frame(27'h7000000, 27'h0800000, 27'h0400000, 27'h0400000, 12'd1000, -1, 1'b1);
        finish_frame();
        check("col_in_set", rec_data[0], 8'h00);
        check("col_zero", rec_data[1], 8'h03);
        check("col_five", rec_data[2], 8'h1F);
        check("col_clamp", rec_data[3], 8'hFF);

        // go while busy must not restart or relatch the view
        start_frame(27'h7800000, 27'h0400000, 27'h0100000, 27'h0200000, 12'd30, -1, 1'b0);
        wait_pix(3);
        @(negedge clock);
        go = 1'b1;
        x_start = 27'h0123456;
        dx = 27'h0000777;
        @(negedge clock);
        go = 1'b0;
        finish_frame();

        // reset during WAIT of pixel 5
        start_frame(27'h7000000, 27'h0800000, 27'h0400000, 27'h0400000, 12'd50, 3, 1'b0);
        wait_pix(6);
        @(negedge clock);
        frame_act = 1'b0;
        reset = 1'b0;
        #1;
        check("midrst_we", bus.mem_we, 0);
        check("midrst_busy", busy, 0);
        check("midrst_frame_cycles", frame_cycles, 0);
        check("midrst_addr", bus.mem_addr, 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        start_frame(27'h7C00000, 27'h0200000, 27'h0080000, 27'h0040000, 12'd15, -1, 1'b0);
        finish_frame();
        check("restart_cr0", rec_cr[0], 27'h7C00000);
        check("restart_ci0", rec_ci[0], 27'h0200000);

        // wrap without saturation
        start_frame(27'h3FFFFFF, 27'h0000000, 27'h0000001, 27'h0000001, 12'd8, -1, 1'b0);
        finish_frame();
        check("wrap_cr1", rec_cr[1], 27'h4000000);

        // max_iter of zero paints everything black
        start_frame(27'h0000000, 27'h0000000, 27'h0001000, 27'h0001000, 12'd0, -1, 1'b0);
        finish_frame();
        for (int p = 0; p < NPIX; p++) check("black_frame", rec_data[p], 8'h00);

        // random views
        for (int f = 0; f < 4; f++) begin
            start_frame(27'($urandom), 27'($urandom), 27'($urandom), 27'($urandom),
                        12'($urandom_range(0, 300)), -1, 1'b0);
            finish_frame();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
